// File: rtl/vend_ctrl_multi.sv
// -----------------------------------------------------------------------------
// vend_ctrl_multi
// Multi-product vending controller. It accepts coins, accumulates credit and
// vends one of NUM_PROD products, each with its own price and milk requirement.
// A vend returns change. After a period of inactivity the full credit is refunded.
//
// Optional feature macro: VEND_CANCEL_EN
//   When defined, the input port "cancel" is added. Asserting it in COUNTING
//   forces a refund. It takes priority over coins and selections, and any coin
//   on the same cycle is rejected.
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   power_on            machine enabled; while low, coins and selections are
//                       ignored in IDLE/COUNTING
//   coin_inserted       one-cycle coin strobe; coin_in carries value 1..3
//   sel_valid, sel      one-cycle selection strobe and product index
//   milk_present        milk reservoir level OK
//   cancel              (VEND_CANCEL_EN only) request refund of credit
//   dispense            one-cycle vend pulse with dispense_sel and change
//   refund              one-cycle refund pulse with refund_amt
//   coin_reject         one-cycle pulse: coin returned, not credited
//   sel_error           one-cycle pulse: selection refused
//   credit              current accumulated credit
//
// State | meaning
//   IDLE     | no credit; waiting for the first coin
//   COUNTING | credit held; coins accumulate, inactivity timer runs
//   DISPENSE | vend pulse cycle; credit clears on exit
//   REFUND   | refund pulse cycle; credit clears on exit
// -----------------------------------------------------------------------------
module vend_ctrl_multi #(
    parameter int                        NUM_PROD    = 4,
    parameter int                        SEL_W       = 2,
    parameter int                        CRED_W      = 5,
    parameter logic [NUM_PROD*CRED_W-1:0] PRICE_LIST = {5'd9, 5'd7, 5'd6, 5'd5},
    parameter logic [NUM_PROD-1:0]       MILK_MASK   = 4'b1010,
    parameter int                        MAX_CREDIT  = 20,
    parameter int                        TIMEOUT_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              power_on,
    input  logic              coin_inserted,
    input  logic [1:0]        coin_in,
    input  logic              sel_valid,
    input  logic [SEL_W-1:0]  sel,
    input  logic              milk_present,
`ifdef VEND_CANCEL_EN
    input  logic              cancel,
`endif
    output logic              dispense,
    output logic [SEL_W-1:0]  dispense_sel,
    output logic [CRED_W-1:0] change,
    output logic              refund,
    output logic [CRED_W-1:0] refund_amt,
    output logic              coin_reject,
    output logic              sel_error,
    output logic [CRED_W-1:0] credit
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, COUNTING, DISPENSE, REFUND} state_t;

    state_t            state, state_n;
    logic [TMR_W-1:0]  timer, timer_n;
    logic [CRED_W-1:0] credit_n, credit_eff, price;
    logic [CRED_W-1:0] change_n, refund_amt_n;
    logic [SEL_W-1:0]  dispense_sel_n;
    logic              dispense_n, refund_n, coin_reject_n, sel_error_n;
    logic [CRED_W:0]   coin_sum;
    logic              coin_ok, need_milk, sel_in_range, cancel_req;

`ifdef VEND_CANCEL_EN
    assign cancel_req = cancel;
`else
    assign cancel_req = 1'b0;
`endif

    // The sum is one bit wider than credit, so the ceiling compare cannot wrap.
    assign coin_sum     = (CRED_W+1)'(credit) + (CRED_W+1)'(coin_in);
    assign coin_ok      = (coin_in != 2'd0) && (coin_sum <= (CRED_W+1)'(MAX_CREDIT));
    assign sel_in_range = (32'(sel) < NUM_PROD);

    // The loop lookup never indexes past the table when sel >= NUM_PROD.
    always_comb begin
        price     = '0;
        need_milk = 1'b0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (32'(sel) == i) begin
                price     = PRICE_LIST[i*CRED_W +: CRED_W];
                need_milk = MILK_MASK[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            credit       <= '0;
            dispense     <= 1'b0;
            dispense_sel <= '0;
            change       <= '0;
            refund       <= 1'b0;
            refund_amt   <= '0;
            coin_reject  <= 1'b0;
            sel_error    <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            credit       <= credit_n;
            dispense     <= dispense_n;
            dispense_sel <= dispense_sel_n;
            change       <= change_n;
            refund       <= refund_n;
            refund_amt   <= refund_amt_n;
            coin_reject  <= coin_reject_n;
            sel_error    <= sel_error_n;
        end
    end

    always_comb begin
        state_n        = state;
        timer_n        = timer;
        credit_n       = credit;
        credit_eff     = credit;
        dispense_n     = 1'b0;
        dispense_sel_n = '0;
        change_n       = '0;
        refund_n       = 1'b0;
        refund_amt_n   = '0;
        coin_reject_n  = 1'b0;
        sel_error_n    = 1'b0;

        case (state)
            IDLE: begin
                if (power_on) begin
                    if (coin_inserted) begin
                        if (coin_ok) begin
                            credit_n = coin_sum[CRED_W-1:0];
                            timer_n  = '0;
                            state_n  = COUNTING;
                        end else begin
                            coin_reject_n = 1'b1;
                        end
                    end
                    if (sel_valid) sel_error_n = 1'b1;
                end
            end
            COUNTING: begin
                if (power_on) begin
                    if (cancel_req) begin
                        state_n       = REFUND;
                        refund_n      = 1'b1;
                        refund_amt_n  = credit;
                        coin_reject_n = coin_inserted;
                    end else begin
                        // A coin is credited first, so a selection in the same
                        // cycle is judged against the updated credit.
                        if (coin_inserted) begin
                            if (coin_ok) begin
                                credit_eff = coin_sum[CRED_W-1:0];
                                timer_n    = '0;
                            end else begin
                                coin_reject_n = 1'b1;
                            end
                        end
                        credit_n = credit_eff;
                        if (sel_valid) begin
                            if (!sel_in_range || (credit_eff < price) ||
                                (need_milk && !milk_present)) begin
                                sel_error_n = 1'b1;
                                timer_n     = '0;
                            end else begin
                                state_n        = DISPENSE;
                                dispense_n     = 1'b1;
                                dispense_sel_n = sel;
                                change_n       = credit_eff - price;
                            end
                        end else if (!coin_inserted) begin
                            if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                                state_n      = REFUND;
                                refund_n     = 1'b1;
                                refund_amt_n = credit;
                            end else begin
                                timer_n = timer + 1'b1;
                            end
                        end
                    end
                end
            end
            DISPENSE, REFUND: begin
                credit_n      = '0;
                timer_n       = '0;
                state_n       = IDLE;
                coin_reject_n = coin_inserted;
                sel_error_n   = sel_valid;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
module tb_vend_ctrl_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic       power_on;
    logic       coin_inserted;
    logic [1:0] coin_in;
    logic       sel_valid;
    logic [1:0] sel;
    logic       milk_present;
`ifdef VEND_CANCEL_EN
    logic       cancel;
`endif
    logic       dispense;
    logic [1:0] dispense_sel;
    logic [4:0] change;
    logic       refund;
    logic [4:0] refund_amt;
    logic       coin_reject;
    logic       sel_error;
    logic [4:0] credit;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       d;
        logic [1:0] ds;
        logic [4:0] ch;
        logic       r;
        logic [4:0] ra;
        logic       rej;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    exp_t act_m, exp_m;

    vend_ctrl_multi dut (
        .clk          (clk),
        .reset        (reset),
        .power_on     (power_on),
        .coin_inserted(coin_inserted),
        .coin_in      (coin_in),
        .sel_valid    (sel_valid),
        .sel          (sel),
        .milk_present (milk_present),
`ifdef VEND_CANCEL_EN
        .cancel       (cancel),
`endif
        .dispense     (dispense),
        .dispense_sel (dispense_sel),
        .change       (change),
        .refund       (refund),
        .refund_amt   (refund_amt),
        .coin_reject  (coin_reject),
        .sel_error    (sel_error),
        .credit       (credit)
    );

    always #5 clk = ~clk;

    // Monitor: any pulse from the DUT must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && (dispense || refund || coin_reject || sel_error)) begin
            act_m = '{dispense, dispense_sel, change, refund, refund_amt, coin_reject, sel_error};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse t=%0t act d=%0b ds=%0d ch=%0d r=%0b ra=%0d rej=%0b err=%0b required none",
                         $time, act_m.d, act_m.ds, act_m.ch, act_m.r, act_m.ra, act_m.rej, act_m.err);
            end else begin
                exp_m = exp_q.pop_front();
                if (act_m !== exp_m) begin
                    failures++;
                    $display("FAIL pulse t=%0t act d=%0b ds=%0d ch=%0d r=%0b ra=%0d rej=%0b err=%0b req d=%0b ds=%0d ch=%0d r=%0b ra=%0d rej=%0b err=%0b",
                             $time, act_m.d, act_m.ds, act_m.ch, act_m.r, act_m.ra, act_m.rej, act_m.err,
                             exp_m.d, exp_m.ds, exp_m.ch, exp_m.r, exp_m.ra, exp_m.rej, exp_m.err);
                end
            end
        end
    end

    task automatic push(input logic d, input logic [1:0] ds, input logic [4:0] ch,
                        input logic r, input logic [4:0] ra, input logic rej, input logic err);
        exp_t e;
        e = '{d, ds, ch, r, ra, rej, err};
        exp_q.push_back(e);
    endtask

    task automatic step(input logic cv, input logic [1:0] c, input logic sv, input logic [1:0] s);
        coin_inserted = cv;
        coin_in       = c;
        sel_valid     = sv;
        sel           = s;
        @(negedge clk);
        coin_inserted = 1'b0;
        coin_in       = 2'd0;
        sel_valid     = 1'b0;
        sel           = 2'd0;
    endtask

    task automatic coin(input logic [1:0] c);
        step(1'b1, c, 1'b0, 2'd0);
    endtask

    task automatic select(input logic [1:0] s);
        step(1'b0, 2'd0, 1'b1, s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 2'd0);
    endtask

    task automatic chk_credit(input string name, input logic [4:0] v);
        checks++;
        if (credit !== v) begin
            failures++;
            $display("FAIL %s credit act=%0d req=%0d", name, credit, v);
        end
    endtask

    initial begin
        reset         = 1'b1;
        power_on      = 1'b1;
        coin_inserted = 1'b0;
        coin_in       = 2'd0;
        sel_valid     = 1'b0;
        sel           = 2'd0;
        milk_present  = 1'b1;
`ifdef VEND_CANCEL_EN
        cancel        = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++;
        if ({dispense, dispense_sel, change, refund, refund_amt, coin_reject, sel_error, credit} !== '0) begin
            failures++;
            $display("FAIL reset_outputs act=%h req=0",
                     {dispense, dispense_sel, change, refund, refund_amt, coin_reject, sel_error, credit});
        end
        reset = 1'b0;

        // Product 1 costs 6, so credit 7 leaves 1 change.
        coin(3); coin(2); coin(2);
        chk_credit("t1_acc", 5'd7);
        push(1, 2'd1, 5'd1, 0, 5'd0, 0, 0); select(2'd1);
        chk_credit("t1_during_dispense", 5'd7);
        idle(1);
        chk_credit("t1_cleared", 5'd0);

        // Product 0 costs 5, then a zero-value coin is rejected.
        coin(3); coin(3); coin(3);
        push(1, 2'd0, 5'd4, 0, 5'd0, 0, 0); select(2'd0);
        idle(1);
        push(0, 2'd0, 5'd0, 0, 5'd0, 1, 0); coin(0);
        chk_credit("t2_zero_coin", 5'd0);

        // Product 3 needs milk.
        milk_present = 1'b0;
        coin(3); coin(3); coin(3);
        push(0, 2'd0, 5'd0, 0, 5'd0, 0, 1); select(2'd3);
        chk_credit("t3_no_milk", 5'd9);
        milk_present = 1'b1;
        push(1, 2'd3, 5'd0, 0, 5'd0, 0, 0); select(2'd3);
        idle(1);
        chk_credit("t3_cleared", 5'd0);

        // Timeout refund four idle cycles after the last coin.
        coin(3); coin(2); coin(1);
        idle(3);
        chk_credit("t4_before_timeout", 5'd6);
        push(0, 2'd0, 5'd0, 1, 5'd6, 0, 0); idle(1);
        idle(1);
        chk_credit("t4_after_refund", 5'd0);

        // A coin on the third idle cycle restarts the timer.
        coin(3); idle(2); coin(2);
        idle(3);
        chk_credit("t4_restart", 5'd5);
        push(0, 2'd0, 5'd0, 1, 5'd5, 0, 0); idle(1);
        idle(1);
        chk_credit("t4_restart_cleared", 5'd0);

        // Credit ceiling: 21 exceeds the limit, 20 is accepted.
        repeat (6) coin(3);
        chk_credit("t5_18", 5'd18);
        push(0, 2'd0, 5'd0, 0, 5'd0, 1, 0); coin(3);
        chk_credit("t5_over", 5'd18);
        coin(2);
        chk_credit("t5_at_max", 5'd20);

        // With power off, inputs are ignored and the timer is frozen.
        power_on = 1'b0;
        coin(1); select(2'd0); idle(6);
        chk_credit("t5_power_off", 5'd20);
        power_on = 1'b1;
        push(1, 2'd0, 5'd15, 0, 5'd0, 0, 0); select(2'd0);
        idle(1);
        chk_credit("t5_after_vend", 5'd0);

        // A selection in IDLE is refused.
        push(0, 2'd0, 5'd0, 0, 5'd0, 0, 1); select(2'd0);
        chk_credit("t5_idle_sel", 5'd0);

        // The coin is credited before the selection in the same cycle
        // (3 + 3 = 6 against price 5). A coin during DISPENSE is rejected.
        coin(3);
        push(1, 2'd0, 5'd1, 0, 5'd0, 0, 0); step(1'b1, 2'd3, 1'b1, 2'd0);
        push(0, 2'd0, 5'd0, 0, 5'd0, 1, 0); coin(3);
        chk_credit("t5_coin_in_dispense", 5'd0);

        // Reset mid-operation discards credit silently.
        coin(3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_credit("reset_mid", 5'd0);
        idle(6);

`ifdef VEND_CANCEL_EN
        coin(3); coin(2);
        cancel = 1'b1;
        push(0, 2'd0, 5'd0, 1, 5'd5, 1, 0); coin(3);
        cancel = 1'b0;
        idle(1);
        chk_credit("t6_cancel", 5'd0);
`endif

        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_pulses act_outstanding=%0d req=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
